// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: segment-limit check, word-split D-cache accesses
// over req/ack, read merge with zero-extension, and write byte-enable generation.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_v,
  input  logic        i_inv,
  input  logic        i_memRen,
  input  logic        i_memWen,
  input  logic [31:0] i_virt_addr,
  input  logic [31:0] i_segRc_lim,
  input  logic [1:0]  i_opSize,
  input  logic [31:0] i_wdata,
  input  logic        i_stall,
  output logic        o_stall,
  output logic        o_v,
  output logic [31:0] o_rdata,
  output logic        o_gp_fault,
  output logic        o_dc_req,
  output logic        o_dc_we,
  output logic [31:0] o_dc_addr,
  output logic [3:0]  o_dc_be,
  output logic [31:0] o_dc_wdata,
  input  logic        i_dc_ack,
  input  logic [31:0] i_dc_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  state_t      w_accept_state;

  logic [1:0]  r_off;
  logic [31:0] r_dmask;
  logic        r_we;
  logic        r_split;
  logic        r_flush;
  logic [3:0]  r_be_hi;
  logic [31:0] r_wd_hi;
  logic [31:0] r_w0;

  logic        w_accept;
  logic        w_memop;
  logic        w_fault;
  logic        w_flush;
  logic [1:0]  w_off;
  logic [3:0]  w_mask4;
  logic [31:0] w_dmask;
  logic [7:0]  w_be64;
  logic [63:0] w_wd64;
  logic [31:0] w_lo;
  logic [31:0] w_hi;
  logic [63:0] w_shift64;
  logic [31:0] w_result;

  // Decode of the incoming uop (only meaningful when it is accepted)
  assign w_off   = i_virt_addr[1:0];
  assign w_memop = i_memRen | i_memWen;
  assign w_fault = i_virt_addr > i_segRc_lim;

  always_comb begin
    w_mask4 = 4'b0001;
    w_dmask = 32'h0000_00FF;
    case (i_opSize)
      2'b10: begin
        w_mask4 = 4'b0011;
        w_dmask = 32'h0000_FFFF;
      end
      2'b11: begin
        w_mask4 = 4'b1111;
        w_dmask = 32'hFFFF_FFFF;
      end
      default: begin
        w_mask4 = 4'b0001;
        w_dmask = 32'h0000_00FF;
      end
    endcase
  end

  assign w_be64 = {4'b0000, w_mask4} << w_off;
  assign w_wd64 = {32'h0000_0000, i_wdata} << {w_off, 3'b000};

  assign w_accept = i_v & ~i_inv &
                    ((r_state == IDLE) | ((r_state == DONE) & ~i_stall));
  assign w_flush  = r_flush | i_inv;

  // Read merge: in ACC0 the ack word is the low word and the high word is zero
  assign w_lo      = (r_state == ACC1) ? r_w0 : i_dc_rdata;
  assign w_hi      = (r_state == ACC1) ? i_dc_rdata : 32'h0000_0000;
  assign w_shift64 = {w_hi, w_lo} >> {r_off, 3'b000};
  assign w_result  = w_shift64[31:0] & r_dmask;

  assign o_stall = (r_state == ACC0) | (r_state == ACC1) | ((r_state == DONE) & i_stall);
  assign o_v     = (r_state == DONE);

  always_comb begin
    w_accept_state = ACC0;
    if (!w_memop || w_fault) begin
      w_accept_state = DONE;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_accept_state;
        end
      end
      ACC0: begin
        if (i_dc_ack) begin
          // A flushed read stops after the first access; a write always finishes
          if (w_flush && !r_we) begin
            w_state_next = IDLE;
          end else if (r_split) begin
            w_state_next = ACC1;
          end else if (w_flush) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      ACC1: begin
        if (i_dc_ack) begin
          w_state_next = w_flush ? IDLE : DONE;
        end
      end
      DONE: begin
        if (i_inv) begin
          w_state_next = IDLE;
        end else if (!i_stall) begin
          w_state_next = w_accept ? w_accept_state : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off      <= 2'b00;
      r_dmask    <= 32'h0000_0000;
      r_we       <= 1'b0;
      r_split    <= 1'b0;
      r_flush    <= 1'b0;
      r_be_hi    <= 4'b0000;
      r_wd_hi    <= 32'h0000_0000;
      r_w0       <= 32'h0000_0000;
      o_rdata    <= 32'h0000_0000;
      o_gp_fault <= 1'b0;
      o_dc_req   <= 1'b0;
      o_dc_we    <= 1'b0;
      o_dc_addr  <= 32'h0000_0000;
      o_dc_be    <= 4'b0000;
      o_dc_wdata <= 32'h0000_0000;
    end else if (w_accept) begin
      r_off      <= w_off;
      r_dmask    <= w_dmask;
      r_we       <= i_memWen;
      r_split    <= |w_be64[7:4];
      r_flush    <= 1'b0;
      r_be_hi    <= w_be64[7:4];
      r_wd_hi    <= w_wd64[63:32];
      o_rdata    <= 32'h0000_0000;
      o_gp_fault <= w_memop & w_fault;
      o_dc_req   <= w_memop & ~w_fault;
      o_dc_we    <= i_memWen;
      o_dc_addr  <= {i_virt_addr[31:2], 2'b00};
      o_dc_be    <= w_be64[3:0];
      o_dc_wdata <= w_wd64[31:0];
    end else begin
      if ((r_state == ACC0) || (r_state == ACC1)) begin
        if (i_inv) begin
          r_flush <= 1'b1;
        end
        if (i_dc_ack) begin
          if (w_state_next == ACC1) begin
            r_w0       <= i_dc_rdata;
            o_dc_addr  <= o_dc_addr + 32'd4;
            o_dc_be    <= r_be_hi;
            o_dc_wdata <= r_wd_hi;
          end else begin
            o_dc_req <= 1'b0;
            o_rdata  <= r_we ? 32'h0000_0000 : w_result;
          end
        end
      end
      if ((r_state == DONE) && (w_state_next != DONE)) begin
        o_gp_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; each task drives one scenario
// and plays the D-cache by hand, comparing against hand-computed values.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_v = 1'b0;
  logic        i_inv = 1'b0;
  logic        i_memRen = 1'b0;
  logic        i_memWen = 1'b0;
  logic [31:0] i_virt_addr = '0;
  logic [31:0] i_segRc_lim = '0;
  logic [1:0]  i_opSize = '0;
  logic [31:0] i_wdata = '0;
  logic        i_stall = 1'b0;
  logic        o_stall;
  logic        o_v;
  logic [31:0] o_rdata;
  logic        o_gp_fault;
  logic        o_dc_req;
  logic        o_dc_we;
  logic [31:0] o_dc_addr;
  logic [3:0]  o_dc_be;
  logic [31:0] o_dc_wdata;
  logic        i_dc_ack = 1'b0;
  logic [31:0] i_dc_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_inv(i_inv), .i_memRen(i_memRen),
    .i_memWen(i_memWen), .i_virt_addr(i_virt_addr), .i_segRc_lim(i_segRc_lim),
    .i_opSize(i_opSize), .i_wdata(i_wdata), .i_stall(i_stall), .o_stall(o_stall),
    .o_v(o_v), .o_rdata(o_rdata), .o_gp_fault(o_gp_fault), .o_dc_req(o_dc_req),
    .o_dc_we(o_dc_we), .o_dc_addr(o_dc_addr), .o_dc_be(o_dc_be),
    .o_dc_wdata(o_dc_wdata), .i_dc_ack(i_dc_ack), .i_dc_rdata(i_dc_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uop(input logic ren, input logic wen, input logic [31:0] a,
                           input logic [31:0] lim, input logic [1:0] sz, input logic [31:0] wd);
    i_v = 1'b1; i_memRen = ren; i_memWen = wen; i_virt_addr = a;
    i_segRc_lim = lim; i_opSize = sz; i_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL reset_v got=%b exp=0", o_v); end
    n_chk++; if (o_dc_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", o_dc_req); end
    n_chk++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    n_chk++; if ({o_rdata, o_dc_addr, o_dc_wdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data got=%h/%h/%h exp=0", o_rdata, o_dc_addr, o_dc_wdata); end
    n_chk++; if ({o_gp_fault, o_dc_we, o_dc_be} !== 6'h0) begin n_fail++; $display("FAIL reset_misc got=%b%b%b exp=0", o_gp_fault, o_dc_we, o_dc_be); end
    $display("test_reset done");
  endtask

  task automatic test_aligned_read();
    drive_uop(1'b1, 1'b0, 32'h1000, 32'h1FFC, 2'b11, 32'h0);
    step();
    i_v = 1'b0;
    n_chk++; if (o_dc_req !== 1'b1 || o_dc_addr !== 32'h1000 || o_dc_be !== 4'hF) begin n_fail++; $display("FAIL t1_req got=%b %h %h exp=1 00001000 f", o_dc_req, o_dc_addr, o_dc_be); end
    n_chk++; if (o_stall !== 1'b1 || o_v !== 1'b0) begin n_fail++; $display("FAIL t1_acc_stall got=%b v=%b exp=1 v=0", o_stall, o_v); end
    i_dc_ack = 1'b1; i_dc_rdata = 32'hAABBCCDD;
    step();
    i_dc_ack = 1'b0;
    n_chk++; if (o_v !== 1'b1 || o_rdata !== 32'hAABBCCDD) begin n_fail++; $display("FAIL t1_result got=%b %h exp=1 aabbccdd", o_v, o_rdata); end
    n_chk++; if (o_dc_req !== 1'b0 || o_gp_fault !== 1'b0) begin n_fail++; $display("FAIL t1_done got req=%b gp=%b exp=0 0", o_dc_req, o_gp_fault); end
    step();
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL t1_vdrop got=%b exp=0", o_v); end
    $display("test_aligned_read done");
  endtask

  task automatic test_split_read();
    drive_uop(1'b1, 1'b0, 32'h1003, 32'h1FFC, 2'b11, 32'h0);
    step();
    i_v = 1'b0;
    n_chk++; if (o_dc_req !== 1'b1 || o_dc_addr !== 32'h1000 || o_dc_be !== 4'b1000) begin n_fail++; $display("FAIL t2_req0 got=%b %h %b exp=1 00001000 1000", o_dc_req, o_dc_addr, o_dc_be); end
    i_dc_ack = 1'b1; i_dc_rdata = 32'h44332211;
    step();
    n_chk++; if (o_dc_req !== 1'b1 || o_dc_addr !== 32'h1004 || o_dc_be !== 4'b0111 || o_v !== 1'b0) begin n_fail++; $display("FAIL t2_req1 got=%b %h %b v=%b exp=1 00001004 0111 v=0", o_dc_req, o_dc_addr, o_dc_be, o_v); end
    i_dc_rdata = 32'h88776655;
    step();
    i_dc_ack = 1'b0;
    n_chk++; if (o_v !== 1'b1 || o_rdata !== 32'h77665544) begin n_fail++; $display("FAIL t2_result got=%b %h exp=1 77665544", o_v, o_rdata); end
    step();
    $display("test_split_read done");
  endtask

  task automatic test_split_write();
    drive_uop(1'b0, 1'b1, 32'h2003, 32'hFFFF_FFFF, 2'b10, 32'h0000BEEF);
    step();
    i_v = 1'b0;
    n_chk++; if (o_dc_we !== 1'b1 || o_dc_addr !== 32'h2000 || o_dc_be !== 4'b1000 || o_dc_wdata !== 32'hEF000000) begin n_fail++; $display("FAIL t3_req0 got=%b %h %b %h exp=1 00002000 1000 ef000000", o_dc_we, o_dc_addr, o_dc_be, o_dc_wdata); end
    i_dc_ack = 1'b1;
    step();
    n_chk++; if (o_dc_req !== 1'b1 || o_dc_addr !== 32'h2004 || o_dc_be !== 4'b0001 || o_dc_wdata !== 32'h000000BE) begin n_fail++; $display("FAIL t3_req1 got=%b %h %b %h exp=1 00002004 0001 000000be", o_dc_req, o_dc_addr, o_dc_be, o_dc_wdata); end
    step();
    i_dc_ack = 1'b0;
    n_chk++; if (o_v !== 1'b1 || o_dc_req !== 1'b0) begin n_fail++; $display("FAIL t3_done got v=%b req=%b exp=1 0", o_v, o_dc_req); end
    step();
    $display("test_split_write done");
  endtask

  task automatic test_fault();
    drive_uop(1'b1, 1'b0, 32'h3000, 32'h2FFF, 2'b11, 32'h0);
    step();
    i_v = 1'b0;
    n_chk++; if (o_dc_req !== 1'b0) begin n_fail++; $display("FAIL t4_noreq got=%b exp=0", o_dc_req); end
    n_chk++; if (o_v !== 1'b1 || o_gp_fault !== 1'b1 || o_stall !== 1'b0) begin n_fail++; $display("FAIL t4_fault got v=%b gp=%b st=%b exp=1 1 0", o_v, o_gp_fault, o_stall); end
    step();
    n_chk++; if (o_v !== 1'b0 || o_gp_fault !== 1'b0) begin n_fail++; $display("FAIL t4_clear got v=%b gp=%b exp=0 0", o_v, o_gp_fault); end
    $display("test_fault done");
  endtask

  task automatic test_stall_wait();
    drive_uop(1'b1, 1'b0, 32'h1004, 32'h1FFC, 2'b11, 32'h0);
    step();
    i_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (o_dc_req !== 1'b1 || o_dc_addr !== 32'h1004 || o_dc_be !== 4'hF || o_stall !== 1'b1) begin n_fail++; $display("FAIL t5_wait%0d got=%b %h %h st=%b exp=1 00001004 f st=1", c, o_dc_req, o_dc_addr, o_dc_be, o_stall); end
      step();
    end
    i_dc_ack = 1'b1; i_dc_rdata = 32'h12345678; i_stall = 1'b1;
    step();
    i_dc_ack = 1'b0; i_dc_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      n_chk++; if (o_v !== 1'b1 || o_rdata !== 32'h12345678 || o_stall !== 1'b1) begin n_fail++; $display("FAIL t5_hold%0d got=%b %h st=%b exp=1 12345678 st=1", c, o_v, o_rdata, o_stall); end
      step();
    end
    i_stall = 1'b0;
    #1;
    n_chk++; if (o_v !== 1'b1 || o_stall !== 1'b0) begin n_fail++; $display("FAIL t5_release got v=%b st=%b exp=1 0", o_v, o_stall); end
    step();
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL t5_vdrop got=%b exp=0", o_v); end
    $display("test_stall_wait done");
  endtask

  task automatic test_back_to_back();
    drive_uop(1'b0, 1'b0, 32'h5000, 32'h0, 2'b11, 32'h0);
    step();
    n_chk++; if (o_v !== 1'b1 || o_rdata !== 32'h0 || o_gp_fault !== 1'b0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_nomem got v=%b %h gp=%b st=%b exp=1 0 0 0", o_v, o_rdata, o_gp_fault, o_stall); end
    drive_uop(1'b1, 1'b0, 32'h3000, 32'h2FFF, 2'b11, 32'h0);
    step();
    i_v = 1'b0;
    n_chk++; if (o_v !== 1'b1 || o_gp_fault !== 1'b1 || o_dc_req !== 1'b0) begin n_fail++; $display("FAIL b2b_fault got v=%b gp=%b req=%b exp=1 1 0", o_v, o_gp_fault, o_dc_req); end
    step();
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b exp=0", o_v); end
    $display("test_back_to_back done");
  endtask

  task automatic test_boundary();
    // Byte at the highest in-limit address, lane 3 of its word
    drive_uop(1'b1, 1'b0, 32'h1007, 32'h1007, 2'b00, 32'h0);
    step();
    i_v = 1'b0;
    n_chk++; if (o_dc_req !== 1'b1 || o_dc_be !== 4'b1000 || o_gp_fault !== 1'b0) begin n_fail++; $display("FAIL bnd_byte_req got=%b %b gp=%b exp=1 1000 0", o_dc_req, o_dc_be, o_gp_fault); end
    i_dc_ack = 1'b1; i_dc_rdata = 32'hA1B2C3D4;
    step();
    i_dc_ack = 1'b0;
    n_chk++; if (o_v !== 1'b1 || o_rdata !== 32'h000000A1) begin n_fail++; $display("FAIL bnd_byte got=%b %h exp=1 000000a1", o_v, o_rdata); end
    step();
    // Split read across the top of the address space
    drive_uop(1'b1, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b11, 32'h0);
    step();
    i_v = 1'b0;
    n_chk++; if (o_dc_addr !== 32'hFFFF_FFFC || o_dc_be !== 4'b1100) begin n_fail++; $display("FAIL bnd_wrap0 got=%h %b exp=fffffffc 1100", o_dc_addr, o_dc_be); end
    i_dc_ack = 1'b1; i_dc_rdata = 32'h11223344;
    step();
    n_chk++; if (o_dc_addr !== 32'h0 || o_dc_be !== 4'b0011) begin n_fail++; $display("FAIL bnd_wrap1 got=%h %b exp=00000000 0011", o_dc_addr, o_dc_be); end
    i_dc_rdata = 32'h55667788;
    step();
    i_dc_ack = 1'b0;
    n_chk++; if (o_v !== 1'b1 || o_rdata !== 32'h77881122) begin n_fail++; $display("FAIL bnd_wrap_data got=%b %h exp=1 77881122", o_v, o_rdata); end
    step();
    $display("test_boundary done");
  endtask

  task automatic test_flush();
    drive_uop(1'b1, 1'b0, 32'h1003, 32'h1FFC, 2'b11, 32'h0);
    step();
    i_v = 1'b0; i_inv = 1'b1;
    step();
    i_inv = 1'b0;
    n_chk++; if (o_dc_req !== 1'b1 || o_dc_addr !== 32'h1000) begin n_fail++; $display("FAIL fl_rd_hold got=%b %h exp=1 00001000", o_dc_req, o_dc_addr); end
    i_dc_ack = 1'b1; i_dc_rdata = 32'h44332211;
    step();
    i_dc_ack = 1'b0;
    n_chk++; if (o_dc_req !== 1'b0 || o_v !== 1'b0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL fl_rd_end got req=%b v=%b st=%b exp=0 0 0", o_dc_req, o_v, o_stall); end
    step();
    n_chk++; if (o_v !== 1'b0 || o_dc_req !== 1'b0) begin n_fail++; $display("FAIL fl_rd_idle got v=%b req=%b exp=0 0", o_v, o_dc_req); end
    drive_uop(1'b0, 1'b1, 32'h2003, 32'hFFFF_FFFF, 2'b10, 32'h0000BEEF);
    step();
    i_v = 1'b0; i_inv = 1'b1; i_dc_ack = 1'b1;
    step();
    i_inv = 1'b0;
    n_chk++; if (o_dc_req !== 1'b1 || o_dc_addr !== 32'h2004 || o_dc_be !== 4'b0001) begin n_fail++; $display("FAIL fl_wr_half2 got=%b %h %b exp=1 00002004 0001", o_dc_req, o_dc_addr, o_dc_be); end
    step();
    i_dc_ack = 1'b0;
    n_chk++; if (o_dc_req !== 1'b0 || o_v !== 1'b0) begin n_fail++; $display("FAIL fl_wr_end got req=%b v=%b exp=0 0", o_dc_req, o_v); end
    // Flush of a stalled result in DONE, then i_v blocked by i_inv
    drive_uop(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    i_stall = 1'b1;
    step();
    i_v = 1'b0; i_inv = 1'b1;
    n_chk++; if (o_v !== 1'b1) begin n_fail++; $display("FAIL fl_done_pre got=%b exp=1", o_v); end
    step();
    i_stall = 1'b0; i_v = 1'b1;
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL fl_done_squash got=%b exp=0", o_v); end
    step();
    i_v = 1'b0; i_inv = 1'b0;
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL fl_block_accept got=%b exp=0", o_v); end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid_access();
    drive_uop(1'b1, 1'b0, 32'h1000, 32'h1FFC, 2'b11, 32'h0);
    step();
    i_v = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (o_dc_req !== 1'b0 || o_stall !== 1'b0 || o_v !== 1'b0) begin n_fail++; $display("FAIL rst_mid got req=%b st=%b v=%b exp=0 0 0", o_dc_req, o_stall, o_v); end
    $display("test_reset_mid_access done");
  endtask

  initial begin
    #1;
    test_reset();
    test_aligned_read();
    test_split_read();
    test_split_write();
    test_fault();
    test_stall_wait();
    test_back_to_back();
    test_boundary();
    test_flush();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
